mem_port_arbiter: RTL and testbench

Arbitrates a single shared memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined core. The block sequences each access over a variable-latency bus handshake and returns per-requester completion pulses, which the hazard logic uses as stall release. Data accesses win contention. An optional streak limiter prevents data traffic from starving fetch. A watchdog aborts accesses that the bus never acknowledges.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter: IF/MEM requesters, data priority, bus watchdog.
// Define ARB_FAIR_EN to build the data-streak limiter that forces fetch grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [2:0]        mem_funct3_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [2:0]        bus_funct3_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

  if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
    $error("MAX_DATA_STREAK must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;
  logic [15:0]       r_wdog;

  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_force_if;
  logic w_grant_mem;

`ifdef ARB_FAIR_EN
  logic [3:0] r_streak;

  assign w_force_if = (r_streak == 4'(MAX_DATA_STREAK)) && if_req_i && mem_req_i;

  // Counts only data grants that actually made fetch wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= 4'd0;
    end else if (r_state == StIdle) begin
      if (w_grant_mem) begin
        r_streak <= if_req_i ? r_streak + 4'd1 : 4'd0;
      end else if (if_req_i) begin
        r_streak <= 4'd0;
      end
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  assign w_grant_mem = mem_req_i && !w_force_if;
  assign w_busy      = (r_state != StIdle);
  assign w_timeout   = (r_wdog == 16'(TIMEOUT_CYCLES));
  // Ack wins over the watchdog when both land in the same cycle.
  assign w_done      = w_busy && (bus_ack_i || w_timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
      r_wdog   <= 16'd0;
    end else begin
      case (r_state)
        StIdle: begin
          r_wdog <= 16'd0;
          if (w_grant_mem) begin
            r_state  <= StBusyMem;
            r_we     <= mem_we_i;
            r_addr   <= mem_addr_i;
            r_wdata  <= mem_wdata_i;
            r_funct3 <= mem_funct3_i;
          end else if (if_req_i) begin
            r_state  <= StBusyIf;
            r_we     <= 1'b0;
            r_addr   <= if_addr_i;
            r_wdata  <= '0;
            r_funct3 <= 3'b010;
          end
        end
        StBusyIf, StBusyMem: begin
          if (w_done) begin
            r_state <= StIdle;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus_req_o    = w_busy;
  assign bus_we_o     = r_we;
  assign bus_addr_o   = r_addr;
  assign bus_wdata_o  = r_wdata;
  assign bus_funct3_o = r_funct3;

  assign if_ready_o  = (r_state == StBusyIf) && w_done;
  assign mem_ready_o = (r_state == StBusyMem) && w_done;
  assign err_o       = w_busy && w_timeout && !bus_ack_i;
  assign if_rdata_o  = (if_ready_o && bus_ack_i) ? bus_rdata_i : '0;
  assign mem_rdata_o = (mem_ready_o && bus_ack_i) ? bus_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus fairness, watchdog and reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_we_i, bus_ack_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ready_o, mem_ready_o, bus_req_o, bus_we_o, err_o;
  logic [2:0]  bus_funct3_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ready_o(if_ready_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_funct3_i(mem_funct3_i), .mem_rdata_o(mem_rdata_o),
    .mem_ready_o(mem_ready_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_funct3_o(bus_funct3_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .err_o(err_o)
  );

  typedef struct {
    logic        ifq, mq, ack;
    logic [31:0] rd;
    logic        ebreq, ebwe;
    logic [31:0] eaddr;
    logic [2:0]  ef3;
    logic        eifr, emr;
    logic [31:0] erd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    if_req_i = 0; mem_req_i = 0; mem_we_i = 0; bus_ack_i = 0; bus_rdata_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[9];
    logic        got[6];
    logic        exp_mem[6];
    int          ngr;
    int          early;

    if_addr_i = 32'h10; mem_addr_i = 32'h100; mem_wdata_i = 32'hDEAD_BEEF;
    mem_funct3_i = 3'b101;
    reset_dut();

    // Reset state
    #1;
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_bus_we", bus_we_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    chk("rst_bus_f3", bus_funct3_o, 0);
    chk("rst_readies", {if_ready_o, mem_ready_o, err_o}, 0);

    // ifq mq ack rd | breq bwe addr f3 | ifr mr erd
    vecs[0] = '{0, 0, 1, 32'h55,       0, 0, 32'h0,   3'b000, 0, 0, 32'h0};
    vecs[1] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,   3'b000, 0, 0, 32'h0};
    vecs[2] = '{1, 0, 1, 32'h0051_3093, 1, 0, 32'h10,  3'b010, 1, 0, 32'h0051_3093};
    vecs[3] = '{1, 1, 0, 32'h0,        0, 0, 32'h0,   3'b000, 0, 0, 32'h0};
    vecs[4] = '{1, 1, 0, 32'h0,        1, 1, 32'h100, 3'b101, 0, 0, 32'h0};
    vecs[5] = '{1, 1, 1, 32'h1234_5678, 1, 1, 32'h100, 3'b101, 0, 1, 32'h1234_5678};
    vecs[6] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,   3'b000, 0, 0, 32'h0};
    vecs[7] = '{1, 0, 1, 32'hCAFE_F00D, 1, 0, 32'h10,  3'b010, 1, 0, 32'hCAFE_F00D};
    vecs[8] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,   3'b000, 0, 0, 32'h0};

    mem_we_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if_req_i = vecs[i].ifq; mem_req_i = vecs[i].mq;
      bus_ack_i = vecs[i].ack; bus_rdata_i = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_bus_req", i), bus_req_o, vecs[i].ebreq);
      if (vecs[i].ebreq) begin
        chk($sformatf("v%0d_bus_we", i), bus_we_o, vecs[i].ebwe);
        chk($sformatf("v%0d_bus_addr", i), bus_addr_o, vecs[i].eaddr);
        chk($sformatf("v%0d_bus_f3", i), bus_funct3_o, vecs[i].ef3);
        if (vecs[i].ebwe) chk($sformatf("v%0d_bus_wdata", i), bus_wdata_o, 32'hDEAD_BEEF);
      end
      chk($sformatf("v%0d_if_ready", i), if_ready_o, vecs[i].eifr);
      chk($sformatf("v%0d_mem_ready", i), mem_ready_o, vecs[i].emr);
      chk($sformatf("v%0d_err", i), err_o, 0);
      chk($sformatf("v%0d_if_rdata", i), if_rdata_o, vecs[i].eifr ? vecs[i].erd : 32'h0);
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata_o, vecs[i].emr ? vecs[i].erd : 32'h0);
      step();
    end
    bus_ack_i = 0;

    // Fairness: both requests held, each grant acked in its first BUSY cycle
    reset_dut();
`ifdef ARB_FAIR_EN
    exp_mem = '{1, 1, 0, 1, 1, 0};
`else
    exp_mem = '{1, 1, 1, 1, 1, 1};
`endif
    ngr = 0;
    if_req_i = 1; mem_req_i = 1; mem_we_i = 0;
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      bus_ack_i = 0;
      #1;
      if (bus_req_o) begin
        got[ngr] = (bus_addr_o == 32'h100);
        ngr++;
        bus_ack_i = 1;
      end
      step();
    end
    bus_ack_i = 0; if_req_i = 0; mem_req_i = 0;
    chk("fair_grant_count", ngr, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("fair_grant%0d_is_mem", i), got[i], exp_mem[i]);

    // Watchdog: load never acked
    reset_dut();
    bus_rdata_i = 32'hFFFF_FFFF;
    mem_req_i = 1; mem_we_i = 0;
    step();
    #1;
    chk("to_bus_req_rise", bus_req_o, 1);
    early = 0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_ready_o || err_o) early++;
      step();
    end
    chk("to_no_early_pulse", early, 0);
    #1;
    chk("to_mem_ready", mem_ready_o, 1);
    chk("to_err", err_o, 1);
    chk("to_mem_rdata_zero", mem_rdata_o, 0);
    mem_req_i = 0;
    step();
    #1;
    chk("to_bus_req_drop", bus_req_o, 0);
    chk("to_err_single", err_o, 0);

    // Ack lands in exactly the timeout cycle
    reset_dut();
    mem_req_i = 1;
    step();
    for (int k = 1; k <= 8; k++) step();
    bus_ack_i = 1; bus_rdata_i = 32'hA5A5_A5A5;
    #1;
    chk("tb_mem_ready", mem_ready_o, 1);
    chk("tb_err_clear", err_o, 0);
    chk("tb_mem_rdata", mem_rdata_o, 32'hA5A5_A5A5);
    mem_req_i = 0;
    step();
    bus_ack_i = 0;
    #1;
    chk("tb_bus_req_drop", bus_req_o, 0);

    // Reset in BUSY_MEM with a fetch pending
    reset_dut();
    mem_req_i = 1; if_req_i = 1; mem_we_i = 1; mem_funct3_i = 3'b001;
    step();
    #1;
    chk("rm_bus_req", bus_req_o, 1);
    chk("rm_bus_we", bus_we_o, 1);
    chk("rm_bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    chk("rm_bus_f3", bus_funct3_o, 3'b001);
    rst = 1;
    #1;
    chk("rm_rst_bus_req", bus_req_o, 0);
    chk("rm_rst_bus_regs", {bus_we_o, bus_funct3_o, bus_addr_o | bus_wdata_o}, 0);
    chk("rm_rst_ready", {if_ready_o, mem_ready_o, err_o}, 0);
    mem_req_i = 0;
    step();
    chk("rm_hold_ready", {if_ready_o, mem_ready_o, bus_req_o}, 0);
    rst = 0;
    step();
    #1;
    chk("rm_if_grant", bus_req_o, 1);
    chk("rm_if_addr", bus_addr_o, 32'h10);
    bus_ack_i = 1; bus_rdata_i = 32'h0BAD_F00D;
    #1;
    chk("rm_if_ready", if_ready_o, 1);
    chk("rm_if_rdata", if_rdata_o, 32'h0BAD_F00D);
    if_req_i = 0;
    step();
    bus_ack_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
